// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK register bank.
// Pure type/constant package; no logic, latency or flow control.
package jk_pkg;

    typedef logic [1:0] jk_mode_t;

    localparam jk_mode_t MODE_JK  = 2'b00;
    localparam jk_mode_t MODE_UP  = 2'b01;
    localparam jk_mode_t MODE_DN  = 2'b10;
    localparam jk_mode_t MODE_SHL = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop bit with async active-low reset to RST_BIT.
// Latency 1 cycle; no backpressure, updates on every rising edge.
module jk_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= RST_BIT;
        else      q_q <= q_d;
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK register bank: per-bit JK, up/down count, shift-left, parallel load.
// Latency 1 cycle; no backpressure; tc/sout combinational from q and mode.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  jk_mode_t         mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             sout
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] qb_w;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic [WIDTH-1:0] ones_run;
    logic [WIDTH-1:0] zeros_run;
    logic [WIDTH-1:0] shift_src;

    // Toggle chains: bit i flips on count when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        ones_run[0]  = 1'b1;
        zeros_run[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            ones_run[i]  = ones_run[i-1] & q_q[i-1];
            zeros_run[i] = zeros_run[i-1] & ~q_q[i-1];
        end
    end

    assign shift_src = {q_q[WIDTH-2:0], sin};

    always_comb begin
        cell_j = '0;
        cell_k = '0;
        if (load) begin
            cell_j = d;
            cell_k = ~d;
        end else if (en) begin
            case (mode)
                MODE_JK: begin
                    cell_j = j;
                    cell_k = k;
                end
                MODE_UP: begin
                    cell_j = ones_run;
                    cell_k = ones_run;
                end
                MODE_DN: begin
                    cell_j = zeros_run;
                    cell_k = zeros_run;
                end
                default: begin
                    cell_j = shift_src;
                    cell_k = ~shift_src;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell #(
            .RST_BIT(RST_VAL[gi])
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .j  (cell_j[gi]),
            .k  (cell_k[gi]),
            .q  (q_q[gi]),
            .qb (qb_w[gi])
        );
    end

    assign q    = q_q;
    assign qb   = qb_w;
    assign sout = q_q[WIDTH-1];
    assign tc   = ((mode == MODE_UP) && (&q_q)) || ((mode == MODE_DN) && (q_q == '0));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: directed literal cases plus random traffic.
module tb_jk_reg_bank;

    localparam int         W   = 8;
    localparam logic [7:0] RV  = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j, k, d;
    logic       load;
    logic       sin;
    logic [7:0] q, qb;
    logic       tc, sout;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] m;   // reference register value

    jk_reg_bank #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .mode(mode),
        .j   (j),
        .k   (k),
        .load(load),
        .d   (d),
        .sin (sin),
        .q   (q),
        .qb  (qb),
        .tc  (tc),
        .sout(sout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model straight from the operating rules.
    always @(posedge clk or negedge rst) begin
        logic [7:0] nx;
        if (!rst) begin
            m <= RV;
        end else begin
            nx = m;
            if (load) begin
                nx = d;
            end else if (en) begin
                case (mode)
                    2'b00: begin
                        for (int i = 0; i < 8; i++) begin
                            case ({j[i], k[i]})
                                2'b01:   nx[i] = 1'b0;
                                2'b10:   nx[i] = 1'b1;
                                2'b11:   nx[i] = ~m[i];
                                default: nx[i] = m[i];
                            endcase
                        end
                    end
                    2'b01:   nx = m + 8'd1;
                    2'b10:   nx = m - 8'd1;
                    default: nx = {m[6:0], sin};
                endcase
            end
            m <= nx;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_tc;
        exp_tc = (mode == 2'b01 && m == 8'hFF) || (mode == 2'b10 && m == 8'h00);
        check("q",    {24'd0, q},    {24'd0, m});
        check("qb",   {24'd0, qb},   {24'd0, ~m});
        check("tc",   {31'd0, tc},   {31'd0, exp_tc});
        check("sout", {31'd0, sout}, {31'd0, m[7]});
    end

    // Returns 2 time units after a rising edge, so inputs change away from edges.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        en = 1'b0; load = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0; sin = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1 rst = 1'b0;
        tick(); tick();
        check("rst_q", {24'd0, q}, 32'h0000_00A5);
        rst = 1'b1;
        tick(); tick(); tick();
        check("hold_after_rst", {24'd0, q}, 32'h0000_00A5);

        // Async reset mid-cycle, visible before the next edge
        load = 1'b1; d = 8'h00;
        tick();
        load = 1'b0;
        check("pre_rst_q", {24'd0, q}, 32'h0000_0000);
        rst = 1'b0;
        #1;
        check("async_rst_q",  {24'd0, q},  32'h0000_00A5);
        check("async_rst_qb", {24'd0, qb}, 32'h0000_005A);
        tick();
        rst = 1'b1;

        // JK mode
        load = 1'b1; d = 8'h0F;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'b00; j = 8'hF0; k = 8'h3C;
        tick();
        check("jk_1", {24'd0, q}, 32'h0000_00F3);
        j = 8'hFF; k = 8'hFF;
        tick();
        check("jk_toggle", {24'd0, q}, 32'h0000_000C);
        idle();

        // Up-count wrap
        load = 1'b1; d = 8'hFE;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'b01;
        #1;
        check("up_q0",  {24'd0, q}, 32'h0000_00FE);
        check("up_tc0", {31'd0, tc}, 32'd0);
        tick();
        check("up_q1",  {24'd0, q}, 32'h0000_00FF);
        check("up_tc1", {31'd0, tc}, 32'd1);
        tick();
        check("up_q2",  {24'd0, q}, 32'h0000_0000);
        check("up_tc2", {31'd0, tc}, 32'd0);
        tick();
        check("up_q3",  {24'd0, q}, 32'h0000_0001);
        idle();

        // Down-count wrap
        load = 1'b1; d = 8'h01;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'b10;
        #1;
        check("dn_tc0", {31'd0, tc}, 32'd0);
        tick();
        check("dn_q1",  {24'd0, q}, 32'h0000_0000);
        check("dn_tc1", {31'd0, tc}, 32'd1);
        tick();
        check("dn_q2",  {24'd0, q}, 32'h0000_00FF);
        check("dn_tc2", {31'd0, tc}, 32'd0);
        load = 1'b1; d = 8'h00; en = 1'b0;
        tick();
        load = 1'b0;
        tick(); tick();
        check("dn_hold_q",  {24'd0, q}, 32'h0000_0000);
        check("dn_hold_tc", {31'd0, tc}, 32'd1);
        idle();

        // Shift-left
        load = 1'b1; d = 8'h81;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'b11; sin = 1'b0;
        #1;
        check("sh_sout0", {31'd0, sout}, 32'd1);
        tick();
        check("sh_q1", {24'd0, q}, 32'h0000_0002);
        sin = 1'b1;
        tick();
        check("sh_q2", {24'd0, q}, 32'h0000_0005);
        tick();
        check("sh_q3", {24'd0, q}, 32'h0000_000B);
        idle();

        // Priority: load beats count; reset beats load
        load = 1'b1; d = 8'h3C; en = 1'b1; mode = 2'b01;
        tick();
        check("prio_load", {24'd0, q}, 32'h0000_003C);
        d = 8'h77;
        rst = 1'b0;
        tick();
        check("prio_rst", {24'd0, q}, 32'h0000_00A5);
        rst = 1'b1;
        idle();
        tick();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            en   = 1'($urandom_range(0, 3) != 0);
            load = 1'($urandom_range(0, 7) == 0);
            mode = 2'($urandom);
            j    = 8'($urandom);
            k    = 8'($urandom);
            d    = 8'($urandom);
            sin  = 1'($urandom);
            rst  = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst = 1'b1;
        idle();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
